// File: rtl/opu_pkg.sv
// Shared widths, mode encodings and Booth digit decode for the opu arithmetic unit.
package opu_pkg;

  localparam int AU_X_W     = 16;
  localparam int AU_Y_W     = 8;
  localparam int AU_P_W     = 32;
  localparam int AU_PP_W    = 17;
  localparam int AU_LATENCY = 3;

  localparam logic AU_MODE_MUL16 = 1'b0;
  localparam logic AU_MODE_DUAL8 = 1'b1;

  // Radix-4 Booth digit: magnitude select (one = 1x, two = 2x) plus negate.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_sel_t;

  function automatic booth_sel_t booth_decode(input logic [2:0] trip);
    booth_sel_t sel;
    sel.neg = trip[2] & ~(trip[1] & trip[0]);
    sel.one = trip[1] ^ trip[0];
    sel.two = (trip == 3'b011) || (trip == 3'b100);
    return sel;
  endfunction

endpackage

// File: rtl/au_mul9x8.sv
// Combinational signed 9x8 -> 17-bit multiplier: radix-4 Booth, four partial
// products, inverted-sign-bit extension with a folded constant, two-level adder tree.
module au_mul9x8
  import opu_pkg::*;
(
  input  logic [8:0]         i_a,
  input  logic [AU_Y_W-1:0]  i_b,
  output logic [AU_PP_W-1:0] o_p
);

  // Sign-extension correction: -(2^10 + 2^12 + 2^14 + 2^16) modulo 2^17.
  localparam logic [AU_PP_W-1:0] SEXT_K = 17'h0AC00;

  logic [AU_Y_W:0]      w_b_ext;
  logic [AU_PP_W-1:0]   w_term [4];
  logic [AU_PP_W-1:0]   w_neg  [4];
  logic [AU_PP_W-1:0]   w_sum01;
  logic [AU_PP_W-1:0]   w_sum23;
  logic [AU_PP_W-1:0]   w_negs;

  assign w_b_ext = {i_b, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pp
      booth_sel_t  w_sel;
      logic [10:0] w_mag;
      logic [10:0] w_pp;

      assign w_sel = booth_decode(w_b_ext[2*gi+2 -: 3]);
      assign w_mag = w_sel.two ? {i_a[8], i_a, 1'b0} :
                     w_sel.one ? {{2{i_a[8]}}, i_a} : 11'd0;
      assign w_pp  = w_mag ^ {11{w_sel.neg}};
      assign w_term[gi] = AU_PP_W'({~w_pp[10], w_pp[9:0]}) << (2 * gi);
      assign w_neg[gi]  = AU_PP_W'(w_sel.neg) << (2 * gi);
    end
  endgenerate

  assign w_sum01 = w_term[0] + w_term[1];
  assign w_sum23 = w_term[2] + w_term[3];
  assign w_negs  = w_neg[0] | w_neg[1] | w_neg[2] | w_neg[3];
  assign o_p     = w_sum01 + w_sum23 + w_negs + SEXT_K;

endmodule

// File: rtl/arithmetic_unit.sv
// Three-stage signed multiplier: one 16x8 product or two packed 8x8 products per
// cycle, sharing two 9x8 Booth multipliers; mode travels with its operands.
module arithmetic_unit
  import opu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [AU_X_W-1:0] x,
  input  logic [AU_Y_W-1:0] y,
  input  logic              mode,
  output logic [AU_P_W-1:0] p
);

  logic [AU_X_W-1:0]  r_x;
  logic [AU_Y_W-1:0]  r_y;
  logic               r_mode1;
  logic [AU_PP_W-1:0] r_pp_hi;
  logic [AU_PP_W-1:0] r_pp_lo;
  logic               r_mode2;
  logic [AU_P_W-1:0]  r_p;

  logic               w_ext;
  logic [8:0]         w_a_hi;
  logic [8:0]         w_a_lo;
  logic [AU_PP_W-1:0] w_pp_hi;
  logic [AU_PP_W-1:0] w_pp_lo;
  logic [AU_P_W-1:0]  w_p_mul16;
  logic [AU_P_W-1:0]  w_p_dual8;

  // In 16x8 mode the low byte is an unsigned digit of x; in packed mode it is a signed lane.
  assign w_ext  = (r_mode1 == AU_MODE_DUAL8) ? r_x[7] : 1'b0;
  assign w_a_hi = {r_x[15], r_x[15:8]};
  assign w_a_lo = {w_ext, r_x[7:0]};

  au_mul9x8 u_mul_hi (
    .i_a (w_a_hi),
    .i_b (r_y),
    .o_p (w_pp_hi)
  );

  au_mul9x8 u_mul_lo (
    .i_a (w_a_lo),
    .i_b (r_y),
    .o_p (w_pp_lo)
  );

  assign w_p_mul16 = {{7{r_pp_hi[16]}}, r_pp_hi, 8'h00} + {{15{r_pp_lo[16]}}, r_pp_lo};
  assign w_p_dual8 = {r_pp_hi[15:0], r_pp_lo[15:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_mode1 <= AU_MODE_MUL16;
      r_pp_hi <= '0;
      r_pp_lo <= '0;
      r_mode2 <= AU_MODE_MUL16;
      r_p     <= '0;
    end else begin
      r_x     <= x;
      r_y     <= y;
      r_mode1 <= mode;
      r_pp_hi <= w_pp_hi;
      r_pp_lo <= w_pp_lo;
      r_mode2 <= r_mode1;
      r_p     <= (r_mode2 == AU_MODE_DUAL8) ? w_p_dual8 : w_p_mul16;
    end
  end

  assign p = r_p;

endmodule

// File: tb/tb_arithmetic_unit.sv
// Self-checking bench for arithmetic_unit: directed corners, alternating-mode
// stream, random regression and asynchronous mid-stream reset.
module tb_arithmetic_unit;
  import opu_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] x;
  logic [7:0]  y;
  logic        mode;
  logic [31:0] p;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  arithmetic_unit dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y),
    .mode  (mode),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer products following the arithmetic definition.
  function automatic logic [31:0] ref_p(input logic [15:0] a, input logic [7:0] b, input logic m);
    int sa, sb, hi, lo, prod;
    logic signed [15:0] a16;
    logic signed [7:0]  b8, ah, al;
    logic [31:0] r;
    a16 = a; b8 = b; ah = a[15:8]; al = a[7:0];
    sa = a16; sb = b8;
    if (m == 1'b0) begin
      prod = sa * sb;
      r = prod;
    end else begin
      hi = int'(ah) * sb;
      lo = int'(al) * sb;
      r = {hi[15:0], lo[15:0]};
    end
    return r;
  endfunction

  task automatic clock_in(input logic [15:0] a, input logic [7:0] b, input logic m);
    x = a; y = b; mode = m;
    exp_q.push_back(ref_p(a, b, m));
    @(posedge clk);
    #1;
  endtask

  task automatic restart_model();
    exp_q.delete();
    repeat (AU_LATENCY - 1) exp_q.push_back(32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (p !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: p=%h required=%h", i, p, 32'h0);
      end else $display("reset_hold cycle %0d p=%h", i, p);
    end
    @(negedge clk);
    reset = 1'b0;
    restart_model();
  endtask

  task automatic test_mode0_corners();
    logic [15:0] tx[3] = '{16'h7FFF, 16'h8000, 16'hFFFF};
    logic [7:0]  ty[3] = '{8'h7F, 8'h80, 8'h01};
    logic [31:0] tp[3] = '{32'h003F7F81, 32'h00400000, 32'hFFFFFFFF};
    logic [31:0] e;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) clock_in(tx[k], ty[k], AU_MODE_MUL16);
      else clock_in(16'h0, 8'h0, AU_MODE_MUL16);
      e = exp_q.pop_front();
      if (k >= 2) e = tp[k-2];
      n_checks++;
      if (p !== e) begin
        n_fail++;
        $display("FAIL mode0_corner step %0d: p=%h required=%h", k, p, e);
      end else $display("mode0_corner step %0d p=%h", k, p);
    end
  endtask

  task automatic test_mode1_lanes();
    logic [15:0] tx[2] = '{16'h7F80, 16'h0203};
    logic [7:0]  ty[2] = '{8'h80, 8'h05};
    logic [31:0] tp[2] = '{32'hC0804000, 32'h000A000F};
    logic [31:0] e;
    for (int k = 0; k < 4; k++) begin
      if (k < 2) clock_in(tx[k], ty[k], AU_MODE_DUAL8);
      else clock_in(16'h0, 8'h0, AU_MODE_DUAL8);
      e = exp_q.pop_front();
      if (k >= 2) e = tp[k-2];
      n_checks++;
      if (p !== e) begin
        n_fail++;
        $display("FAIL mode1_lane step %0d: p=%h required=%h", k, p, e);
      end else $display("mode1_lane step %0d p=%h", k, p);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    for (int k = 0; k < 16; k++) begin
      clock_in(16'($urandom), 8'($urandom), k[0]);
      e = exp_q.pop_front();
      n_checks++;
      if (p !== e) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: p=%h required=%h", k, p, e);
      end else $display("back_to_back step %0d mode=%0d p=%h", k, mode, p);
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int k = 0; k < 40; k++) begin
      clock_in(16'($urandom), 8'($urandom), 1'($urandom));
      e = exp_q.pop_front();
      n_checks++;
      if (p !== e) begin
        n_fail++;
        $display("FAIL random step %0d: p=%h required=%h", k, p, e);
      end else $display("random step %0d x=%h y=%h mode=%0d p=%h", k, x, y, mode, p);
    end
  endtask

  task automatic test_midstream_reset();
    logic [31:0] e;
    for (int k = 0; k < 4; k++) begin
      clock_in(16'h0203, 8'h05, AU_MODE_DUAL8);
      e = exp_q.pop_front();
    end
    n_checks++;
    if (p !== e) begin
      n_fail++;
      $display("FAIL pre_reset: p=%h required=%h", p, e);
    end else $display("pre_reset p=%h", p);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (p !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: p=%h required=%h", p, 32'h0);
    end else $display("async_reset p=%h", p);
    @(negedge clk);
    reset = 1'b0;
    restart_model();
    for (int k = 0; k < 5; k++) begin
      clock_in(16'h7FFF, 8'h7F, AU_MODE_MUL16);
      e = exp_q.pop_front();
      n_checks++;
      if (p !== e) begin
        n_fail++;
        $display("FAIL post_reset step %0d: p=%h required=%h", k, p, e);
      end else $display("post_reset step %0d p=%h", k, p);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_corners();
    test_mode1_lanes();
    test_back_to_back();
    test_random();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
